// File: rtl/titan_fetch_pkg.sv
// Shared encodings and constants for the instruction-fetch Wishbone master.
package titan_fetch_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_HOLD  = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [3:0]  SEL_ALL   = 4'hF;

    function automatic logic misaligned(input logic [31:0] addr);
        return |addr[1:0];
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Bus-response watchdog: counts cycles of an outstanding fetch and flags expiry.
module fetch_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expire) begin
            count <= count + CW'(1);
        end
    end

    // Fires on the last strobed cycle so cyc/stb stay up exactly TIMEOUT_CYCLES cycles.
    assign expire = en && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ifetch_wb_master.sv
// Instruction-fetch Wishbone master: classic single reads, valid/ready to decode.
// Optional response watchdog enabled by defining IFETCH_TIMEOUT_EN.
module ifetch_wb_master
    import titan_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned PC_STEP        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] iaddr_o,
    output logic [31:0] idat_o,
    output logic [3:0]  isel_o,
    output logic        icyc_o,
    output logic        istb_o,
    output logic        iwe_o,
    input  logic [31:0] idat_i,
    input  logic        iack_i,
    input  logic        ierr_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_err_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i
);

    logic [2:0]  state, state_nx;
    logic [31:0] pc, pc_nx, tgt, tgt_nx, addr_nx, instr_nx, instr_pc_nx;
    logic        bus, bus_nx, valid_nx, err_nx;
    logic        resp, resp_err, expire, issue;

    // Responses only count while strobing; the responder's trailing re-ack is dropped here.
    assign resp     = bus & (iack_i | ierr_i | expire);
    assign resp_err = bus & (ierr_i | expire);
    assign issue    = bus_nx & ~bus;

`ifdef IFETCH_TIMEOUT_EN
    fetch_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (issue),
        .en     (bus),
        .expire (expire)
    );
`else
    // No watchdog: a silent responder stalls the fetch indefinitely.
    assign expire = 1'b0 && (TIMEOUT_CYCLES != 0) && issue;
`endif

    assign icyc_o = bus;
    assign istb_o = bus;
    assign isel_o = bus ? SEL_ALL : 4'h0;
    assign idat_o = 32'h0;
    assign iwe_o  = 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (redirect_i) state_nx = misaligned(redirect_pc_i) ? ST_HOLD : ST_WAIT;
                else            state_nx = misaligned(pc) ? ST_HOLD : ST_WAIT;
            end
            ST_WAIT: begin
                if (redirect_i) state_nx = resp ? ST_IDLE : ST_FLUSH;
                else if (resp)  state_nx = ST_HOLD;
            end
            ST_HOLD: begin
                if (redirect_i)         state_nx = misaligned(redirect_pc_i) ? ST_HOLD : ST_WAIT;
                else if (instr_ready_i) state_nx = instr_err_o ? ST_HALT : ST_WAIT;
            end
            ST_HALT: begin
                if (redirect_i) state_nx = misaligned(redirect_pc_i) ? ST_HOLD : ST_WAIT;
            end
            ST_FLUSH: begin
                if (resp) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        bus_nx      = bus;
        addr_nx     = iaddr_o;
        pc_nx       = pc;
        tgt_nx      = tgt;
        valid_nx    = instr_valid_o;
        err_nx      = instr_err_o;
        instr_nx    = instr_o;
        instr_pc_nx = instr_pc_o;
        case (state)
            ST_IDLE, ST_HOLD, ST_HALT: begin
                if (redirect_i) begin
                    valid_nx = 1'b0;
                    pc_nx    = redirect_pc_i;
                    if (misaligned(redirect_pc_i)) begin
                        valid_nx    = 1'b1;
                        err_nx      = 1'b1;
                        instr_nx    = NOP_INSTR;
                        instr_pc_nx = redirect_pc_i;
                    end else begin
                        bus_nx  = 1'b1;
                        addr_nx = redirect_pc_i;
                    end
                end else if (state == ST_IDLE) begin
                    if (misaligned(pc)) begin
                        valid_nx    = 1'b1;
                        err_nx      = 1'b1;
                        instr_nx    = NOP_INSTR;
                        instr_pc_nx = pc;
                    end else begin
                        bus_nx  = 1'b1;
                        addr_nx = pc;
                    end
                end else if (state == ST_HOLD && instr_ready_i) begin
                    valid_nx = 1'b0;
                    if (!instr_err_o) begin
                        bus_nx  = 1'b1;
                        addr_nx = pc;
                    end
                end
            end
            ST_WAIT: begin
                if (redirect_i) begin
                    tgt_nx = redirect_pc_i;
                    // Cycle already finishing: skip FLUSH and restart from the target.
                    if (resp) begin
                        bus_nx = 1'b0;
                        pc_nx  = redirect_pc_i;
                    end
                end else if (resp) begin
                    bus_nx      = 1'b0;
                    valid_nx    = 1'b1;
                    instr_pc_nx = pc;
                    if (resp_err) begin
                        instr_nx = NOP_INSTR;
                        err_nx   = 1'b1;
                    end else begin
                        instr_nx = idat_i;
                        err_nx   = 1'b0;
                        pc_nx    = pc + 32'(PC_STEP);
                    end
                end
            end
            ST_FLUSH: begin
                if (redirect_i) tgt_nx = redirect_pc_i;
                if (resp) begin
                    bus_nx = 1'b0;
                    pc_nx  = redirect_i ? redirect_pc_i : tgt;
                end
            end
            default: begin
                bus_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus           <= 1'b0;
            iaddr_o       <= 32'h0;
            pc            <= RESET_PC;
            tgt           <= 32'h0;
            instr_valid_o <= 1'b0;
            instr_err_o   <= 1'b0;
            instr_o       <= 32'h0;
            instr_pc_o    <= 32'h0;
        end else begin
            bus           <= bus_nx;
            iaddr_o       <= addr_nx;
            pc            <= pc_nx;
            tgt           <= tgt_nx;
            instr_valid_o <= valid_nx;
            instr_err_o   <= err_nx;
            instr_o       <= instr_nx;
            instr_pc_o    <= instr_pc_nx;
        end
    end

endmodule

// File: tb/tb_ifetch_wb_master.sv
// Scoreboard bench for ifetch_wb_master against a registered-ack Wishbone responder.
`timescale 1ns/1ps
module tb_ifetch_wb_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] iaddr, idat_out, idat_in, rpc, instr, instr_pc;
    logic [3:0]  isel;
    logic        icyc, istb, iwe, iack, ierr, redirect, instr_err, instr_valid, ready;

    always #5 clk = ~clk;

    ifetch_wb_master #(
        .RESET_PC       (32'h0000_0000),
        .PC_STEP        (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .iaddr_o       (iaddr),
        .idat_o        (idat_out),
        .isel_o        (isel),
        .icyc_o        (icyc),
        .istb_o        (istb),
        .iwe_o         (iwe),
        .idat_i        (idat_in),
        .iack_i        (iack),
        .ierr_i        (ierr),
        .redirect_i    (redirect),
        .redirect_pc_i (rpc),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_err_o   (instr_err),
        .instr_valid_o (instr_valid),
        .instr_ready_i (ready)
    );

    // Responder: registered ack after 'delay' strobed cycles; keeps acking while stb was high.
    int unsigned delay = 0;
    int unsigned wcnt;
    logic        never_ack = 1'b0;
    logic [31:0] err_addr  = 32'h8;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h0) ? 32'hfff7_0713 : (32'hA500_0000 | a);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            iack <= 1'b0; ierr <= 1'b0; idat_in <= 32'h0; wcnt <= 0;
        end else if (icyc && istb) begin
            idat_in <= mem(iaddr);
            if (!never_ack && wcnt >= delay) begin
                ierr <= (iaddr == err_addr);
                iack <= (iaddr != err_addr);
            end else begin
                iack <= 1'b0; ierr <= 1'b0; wcnt <= wcnt + 1;
            end
        end else begin
            iack <= 1'b0; ierr <= 1'b0; wcnt <= 0;
        end
    end

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;
    int   bus_starts = 0;
    int   stb_cycles = 0;
    logic stb_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic expect_instr(input logic [31:0] i, input logic [31:0] p, input logic e);
        exp_t x;
        x.instr = i; x.pc = p; x.err = e;
        q.push_back(x);
    endtask

    // Monitor: every accepted instruction must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst && instr_valid && ready) begin
            if (q.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_instr: got pc %h instr %h, expected none", instr_pc, instr);
            end else begin
                e = q.pop_front();
                check("instr", instr, e.instr);
                check("instr_pc", instr_pc, e.pc);
                check("instr_err", {31'h0, instr_err}, {31'h0, e.err});
            end
        end
        if (istb && !stb_prev) bus_starts++;
        if (istb) stb_cycles++;
        stb_prev = istb;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [31:0] a);
        redirect = 1'b1; rpc = a;
        tick();
        redirect = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) tick();
        check("queue_drained", q.size(), 0);
        repeat (2) tick();
    endtask

    task automatic wait_sig(input int which, input logic lvl, input int budget);
        logic s;
        for (int i = 0; i < budget; i++) begin
            s = (which == 0) ? istb : instr_valid;
            if (s == lvl) break;
            tick();
        end
        s = (which == 0) ? istb : instr_valid;
        check("wait_bound", {31'h0, s}, {31'h0, lvl});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int s;
        redirect = 1'b0; rpc = 32'h0; ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cyc", {31'h0, icyc}, 0);
        check("rst_stb", {31'h0, istb}, 0);
        check("rst_valid", {31'h0, instr_valid}, 0);
        check("rst_iaddr", iaddr, 0);
        check("rst_instr", instr, 0);

        // Sequential fetch from reset, ending on a bus error at 0x8.
        expect_instr(32'hfff7_0713, 32'h0, 1'b0);
        expect_instr(mem(32'h4), 32'h4, 1'b0);
        expect_instr(32'h0000_0013, 32'h8, 1'b1);
        rst = 1'b1;
        tick();
        check("issue_stb", {31'h0, istb}, 1);
        check("issue_addr", iaddr, 0);
        check("issue_sel", {28'h0, isel}, 32'hF);
        check("issue_we", {31'h0, iwe}, 0);
        check("issue_wdat", idat_out, 0);
        tick();
        check("lat_valid_low", {31'h0, instr_valid}, 0);
        tick();
        check("lat_valid_high", {31'h0, instr_valid}, 1);
        tick();
        check("next_addr", iaddr, 32'h4);
        drain(60);
        s = bus_starts;
        repeat (5) tick();
        check("halt_no_bus", bus_starts, s);
        check("halt_cyc", {31'h0, icyc}, 0);

        // Misaligned redirect: immediate fault, no bus cycle.
        expect_instr(32'h0000_0013, 32'h42, 1'b1);
        s = bus_starts;
        pulse(32'h42);
        check("mis_valid", {31'h0, instr_valid}, 1);
        drain(20);
        check("mis_no_bus", bus_starts, s);

        // Decode back-pressure for 5 cycles.
        ready = 1'b0; err_addr = 32'h10C;
        expect_instr(mem(32'h100), 32'h100, 1'b0);
        expect_instr(mem(32'h104), 32'h104, 1'b0);
        expect_instr(mem(32'h108), 32'h108, 1'b0);
        expect_instr(32'h0000_0013, 32'h10C, 1'b1);
        pulse(32'h100);
        wait_sig(1, 1'b1, 20);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_instr", instr, mem(32'h100));
            check("hold_pc", instr_pc, 32'h100);
            check("hold_cyc", {31'h0, icyc}, 0);
        end
        ready = 1'b1;
        drain(100);

        // Redirect to 0x40 while a slow fetch of 0x200 is outstanding.
        delay = 3; err_addr = 32'h48;
        expect_instr(mem(32'h40), 32'h40, 1'b0);
        expect_instr(mem(32'h44), 32'h44, 1'b0);
        expect_instr(32'h0000_0013, 32'h48, 1'b1);
        pulse(32'h200);
        check("flush_issue_addr", iaddr, 32'h200);
        tick();
        pulse(32'h40);
        wait_sig(0, 1'b0, 20);
        wait_sig(0, 1'b1, 20);
        check("redirect_addr", iaddr, 32'h40);
        drain(200);

`ifdef IFETCH_TIMEOUT_EN
        // Silent responder: watchdog ends the cycle after 16 strobed cycles.
        never_ack = 1'b1;
        expect_instr(32'h0000_0013, 32'h300, 1'b1);
        s = stb_cycles;
        pulse(32'h300);
        wait_sig(1, 1'b1, 40);
        check("timeout_cycles", stb_cycles - s, 16);
        check("timeout_cyc_low", {31'h0, icyc}, 0);
        drain(20);
        never_ack = 1'b0;
`endif

        // Asynchronous reset in the middle of a bus cycle.
        err_addr = 32'hFFFF_FFF0;
        pulse(32'h500);
        check("pre_reset_cyc", {31'h0, icyc}, 1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_cyc", {31'h0, icyc}, 0);
        check("async_rst_stb", {31'h0, istb}, 0);
        check("async_rst_valid", {31'h0, instr_valid}, 0);
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
